mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter: ADDR_W, 16, address width.
REQ-002 Parameter: DATA_W, 16, data width.
REQ-003 Parameter: WAIT_CYCLES, 2, strobe-active cycles per access; legal range 1..15.
REQ-004 Port: Clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port: Reset  in  1  asynchronous, active-low reset.
REQ-006 Port: start  in  1  request strobe from the datapath control; sampled only in IDLE or DONE.
REQ-007 Port: rw  in  1  request type; 1 = read, 0 = write; sampled with start.
REQ-008 Port: mar  in  ADDR_W  address from the MAR selection mux; sampled with start.
REQ-009 Port: mdr_in  in  DATA_W  write data from the MDR selection mux; sampled with start.
REQ-010 Port: mdr_out  out  DATA_W  latched read data to the MDR input mux.
REQ-011 Port: ready  out  1  one-cycle completion pulse.
REQ-012 Port: busy  out  1  high in SETUP, ACCESS and DONE.
REQ-013 Port: mem_addr  out  ADDR_W  registered address to memory.
REQ-014 Port: mem_wdata  out  DATA_W  registered write data.
REQ-015 Port: mem_wdata_oe  out  1  write-data drive enable.
REQ-016 Port: mem_rdata  in  DATA_W  memory read data.
REQ-017 Port: ce_n, oe_n, we_n  out  1 each  active-low memory strobes.
REQ-018 Port: err  out  1  sticky protocol-error flag.

Function
REQ-019 FSM states SHALL be IDLE, SETUP, ACCESS and DONE.
REQ-020 IDLE: start=1 SHALL capture rw/mar/mdr_in and move to SETUP; otherwise remain in IDLE.
REQ-021 SETUP: lasts 1 cycle; ce_n=0, mem_addr valid, oe_n=0 if read, mem_wdata_oe=1 if write, we_n=1.
REQ-022 ACCESS: lasts exactly WAIT_CYCLES cycles; ce_n=0; oe_n=0 for read, we_n=0 and mem_wdata_oe=1 for write.
REQ-023 Read: mdr_out SHALL load mem_rdata on the clock edge that ends the last ACCESS cycle.
REQ-024 DONE: lasts 1 cycle; ready=1, we_n=1, oe_n=1, ce_n=1, mem_wdata_oe stays 1 for write (data hold).
REQ-025 Latency: ready SHALL be high exactly WAIT_CYCLES+2 cycles after the edge that sampled start.
REQ-026 start=1 in DONE SHALL be accepted: go directly to SETUP, no idle bubble; otherwise go to IDLE.
REQ-027 start in SETUP or ACCESS SHALL be ignored and SHALL NOT alter captured rw/mar/mdr_in.
REQ-028 mdr_out SHALL hold its value across writes and idle cycles; it changes only per REQ-023.
REQ-029 we_n and oe_n SHALL never be 0 simultaneously; strobes SHALL be glitch-free (registered).

Reset
REQ-030 Reset low SHALL immediately force IDLE, ce_n=oe_n=we_n=1, mem_wdata_oe=0, ready=0, busy=0, err=0, mdr_out=0, mem_addr=0, mem_wdata=0, wait counter=0.
REQ-031 Reset asserted mid-access SHALL abort the access; no ready pulse SHALL follow reset release.
REQ-032 The first start SHALL be accepted on the first rising edge after reset release.

Configuration
REQ-033 With MEM_CTRL_ERR_EN defined, err SHALL set on start=1 in SETUP or ACCESS and stay set until reset.
REQ-034 Without MEM_CTRL_ERR_EN, err SHALL be tied to 0 and no error logic SHALL be synthesized.

Structure
REQ-035 Package mem_ctrl_pkg SHALL hold the state enum (mem_state_e), the op enum (MEM_READ=1, MEM_WRITE=0) and default width constants.
REQ-036 Sub-module mem_wait_cnt (loadable down-counter, load/dec/zero) SHALL time ACCESS.

Verification
REQ-037 Read: WAIT_CYCLES=2, start, rw=1, mar=0x3000, mem_rdata=0xBEEF -> ready 4 cycles later, mdr_out=0xBEEF, we_n held 1.
REQ-038 Write: start, rw=0, mar=0x0010, mdr_in=0x1234 -> we_n low exactly 2 cycles, mem_wdata=0x1234 with oe through DONE, ready after 4 cycles.
REQ-039 Back-to-back: start held through DONE (read then write) -> second SETUP immediately follows DONE, two ready pulses 4 cycles apart.
REQ-040 Reset mid-ACCESS: Reset low during write -> we_n=1 asynchronously, no ready, next read completes normally.
REQ-041 Error (MEM_CTRL_ERR_EN): start during ACCESS -> err=1 until reset, current access unchanged; without macro err=0.
REQ-042 WAIT_CYCLES=1 and 15 -> ready latency 3 and 17 cycles respectively.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state/op enums and default widths for the memory controller.
package mem_ctrl_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} mem_state_e;
  typedef enum logic {MEM_WRITE = 1'b0, MEM_READ = 1'b1} mem_op_e;
endpackage

// File: rtl/mem_wait_cnt.sv
// mem_wait_cnt: loadable down-counter that times the ACCESS phase.
module mem_wait_cnt
  import mem_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign zero_o = cnt_q == '0;
  always_comb cnt_d = load_i ? val_i : (dec_i && !zero_o) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: IDLE/SETUP/ACCESS/DONE async-SRAM strobe sequencer with registered outputs.
// Optional sticky protocol-error flag enabled by defining MEM_CTRL_ERR_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] mar,
  input  logic [DATA_W-1:0] mdr_in,
  output logic [DATA_W-1:0] mdr_out,
  output logic              ready,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ce_n,
  output logic              oe_n,
  output logic              we_n,
  output logic              err
);
  mem_state_e        state_q;
  mem_op_e           rw_q;
  logic [DATA_W-1:0] mdr_q, wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ready_q, busy_q, wdata_oe_q, ce_n_q, oe_n_q, we_n_q, cnt_zero;

  mem_wait_cnt u_wait (
    .clk   (Clk),
    .rst_n (Reset),
    .load_i(state_q == SETUP),
    .dec_i (state_q == ACCESS),
    .val_i (CNT_W'(WAIT_CYCLES - 1)),
    .zero_o(cnt_zero)
  );

  // Strobes are computed for the state being entered so they toggle only on clock edges.
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      state_q    <= IDLE;
      rw_q       <= MEM_WRITE;
      mdr_q      <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      wdata_oe_q <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE, DONE:
          if (start) begin
            state_q    <= SETUP;
            rw_q       <= mem_op_e'(rw);
            addr_q     <= mar;
            wdata_q    <= mdr_in;
            busy_q     <= 1'b1;
            ce_n_q     <= 1'b0;
            oe_n_q     <= !rw;
            we_n_q     <= 1'b1;
            wdata_oe_q <= !rw;
          end else begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            wdata_oe_q <= 1'b0;
          end
        SETUP: begin
          state_q <= ACCESS;
          we_n_q  <= rw_q == MEM_READ;
        end
        ACCESS:
          if (cnt_zero) begin
            state_q <= DONE;
            ready_q <= 1'b1;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            if (rw_q == MEM_READ) mdr_q <= mem_rdata;
          end
      endcase
    end

`ifdef MEM_CTRL_ERR_EN
  logic err_q;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) err_q <= 1'b0;
    else if (start && (state_q == SETUP || state_q == ACCESS)) err_q <= 1'b1;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign mdr_out      = mdr_q;
  assign ready        = ready_q;
  assign busy         = busy_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_wdata_oe = wdata_oe_q;
  assign ce_n         = ce_n_q;
  assign oe_n         = oe_n_q;
  assign we_n         = we_n_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl (WAIT_CYCLES 2, 1 and 15 instances).
module tb_mem_ctrl;
  logic        Clk = 1'b0, Reset = 1'b1, start = 1'b0, rw = 1'b0;
  logic [15:0] mar = '0, mdr_in = '0, mem_rdata = '0;
  logic [15:0] mdr_out, mem_addr, mem_wdata;
  logic        ready, busy, mem_wdata_oe, ce_n, oe_n, we_n, err;
  logic        st1 = 1'b0, st15 = 1'b0, rdy1, rdy15;
  logic [15:0] mdr1, addr1, wd1, mdr15, addr15, wd15;
  logic        busy1, wdoe1, ce1, oe1, we1, err1, busy15, wdoe15, ce15, oe15, we15, err15;
  logic        ovl = 1'b0;
  int          checks = 0, fails = 0;
  int          lat, wlow;
  logic [4:0]  s1, s2;
  logic        exp_err;

  always #5 Clk = ~Clk;

  mem_ctrl #(.WAIT_CYCLES(2)) u_dut (
    .Clk(Clk), .Reset(Reset), .start(start), .rw(rw), .mar(mar), .mdr_in(mdr_in),
    .mdr_out(mdr_out), .ready(ready), .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata), .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n),
    .err(err));
  mem_ctrl #(.WAIT_CYCLES(1)) u_w1 (
    .Clk(Clk), .Reset(Reset), .start(st1), .rw(rw), .mar(mar), .mdr_in(mdr_in),
    .mdr_out(mdr1), .ready(rdy1), .busy(busy1), .mem_addr(addr1), .mem_wdata(wd1),
    .mem_wdata_oe(wdoe1), .mem_rdata(mem_rdata), .ce_n(ce1), .oe_n(oe1), .we_n(we1), .err(err1));
  mem_ctrl #(.WAIT_CYCLES(15)) u_w15 (
    .Clk(Clk), .Reset(Reset), .start(st15), .rw(rw), .mar(mar), .mdr_in(mdr_in),
    .mdr_out(mdr15), .ready(rdy15), .busy(busy15), .mem_addr(addr15), .mem_wdata(wd15),
    .mem_wdata_oe(wdoe15), .mem_rdata(mem_rdata), .ce_n(ce15), .oe_n(oe15), .we_n(we15),
    .err(err15));

  always @(negedge Clk) if (!oe_n && !we_n) ovl = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issues one request on the W=2 instance; returns at the negedge where ready is seen.
  task automatic run(input logic r, input logic [15:0] a, d, rd,
                     output int l, output int wl, output logic [4:0] x1, output logic [4:0] x2);
    start = 1'b1; rw = r; mar = a; mdr_in = d; mem_rdata = rd;
    @(posedge Clk); #1 start = 1'b0;
    l = 0; wl = 0; x1 = '0; x2 = '0;
    for (int n = 1; n <= 40 && l == 0; n++) begin
      @(negedge Clk);
      if (n == 1) x1 = {ce_n, oe_n, we_n, mem_wdata_oe, busy};
      if (n == 2) x2 = {ce_n, oe_n, we_n, mem_wdata_oe, busy};
      if (!we_n) wl++;
      if (ready) l = n;
    end
  endtask

  task automatic lat_x(input int k, output int l);
    if (k == 1) st1 = 1'b1; else st15 = 1'b1;
    rw = 1'b1;
    @(posedge Clk); #1 st1 = 1'b0; st15 = 1'b0;
    l = 0;
    for (int n = 1; n <= 40 && l == 0; n++) begin
      @(negedge Clk);
      if ((k == 1) ? rdy1 : rdy15) l = n;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef MEM_CTRL_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    #3 Reset = 1'b0;
    #1;
    chk("rst_strobes", {ce_n, oe_n, we_n, mem_wdata_oe}, 4'b1110);
    chk("rst_flags", {ready, busy, err}, 3'b000);
    chk("rst_data", {mdr_out, mem_addr, mem_wdata}, 48'h0);
    @(negedge Clk); @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);

    run(1'b1, 16'h3000, 16'h0000, 16'hBEEF, lat, wlow, s1, s2);
    chk("rd_lat", lat, 4);
    chk("rd_setup", s1, 5'b00101);
    chk("rd_access", s2, 5'b00101);
    chk("rd_we_low", wlow, 0);
    chk("rd_done_strobes", {ce_n, oe_n, we_n, mem_wdata_oe}, 4'b1110);
    chk("rd_mdr", mdr_out, 16'hBEEF);
    chk("rd_addr", mem_addr, 16'h3000);
    @(negedge Clk);
    chk("rd_idle", {ready, busy}, 2'b00);

    run(1'b0, 16'h0010, 16'h1234, 16'h0BAD, lat, wlow, s1, s2);
    chk("wr_lat", lat, 4);
    chk("wr_setup", s1, 5'b01111);
    chk("wr_access", s2, 5'b01011);
    chk("wr_we_low", wlow, 2);
    chk("wr_done", {ce_n, oe_n, we_n, mem_wdata_oe}, 4'b1111);
    chk("wr_data", {mem_addr, mem_wdata}, {16'h0010, 16'h1234});
    chk("wr_mdr_hold", mdr_out, 16'hBEEF);
    @(negedge Clk);
    chk("wr_idle", {ready, busy, mem_wdata_oe}, 3'b000);
    chk("idle_mdr_hold", mdr_out, 16'hBEEF);

    start = 1'b1; rw = 1'b1; mar = 16'h0100; mem_rdata = 16'h5555;
    @(posedge Clk); #1 rw = 1'b0; mar = 16'h0200; mdr_in = 16'hAAAA;
    @(negedge Clk); @(negedge Clk); @(negedge Clk);
    chk("b2b_capture_held", {mem_addr, oe_n}, {16'h0100, 1'b0});
    @(negedge Clk);
    chk("b2b_first_ready", {ready, mdr_out}, {1'b1, 16'h5555});
    @(posedge Clk); #1 start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge Clk);
      if (n == 1) chk("b2b_no_bubble", {busy, ce_n, we_n, mem_wdata_oe, ready}, 5'b10110);
      if (ready) lat = n;
    end
    chk("b2b_second_lat", lat, 4);
    chk("b2b_wdata", {mem_addr, mem_wdata}, {16'h0200, 16'hAAAA});
    @(negedge Clk);

    start = 1'b1; rw = 1'b0; mar = 16'h0040; mdr_in = 16'h4242;
    @(posedge Clk); #1 start = 1'b0;
    @(negedge Clk); @(negedge Clk);
    start = 1'b1; rw = 1'b1; mar = 16'hFFFF; mdr_in = 16'h0000;
    @(posedge Clk); #1 start = 1'b0;
    @(negedge Clk);
    chk("err_access_kept", {mem_addr, mem_wdata, we_n}, {16'h0040, 16'h4242, 1'b0});
    @(negedge Clk);
    chk("err_done", {ready, mem_wdata_oe}, 2'b11);
    chk("err_flag", err, exp_err);
    repeat (3) @(negedge Clk);
    chk("err_sticky", err, exp_err);

    start = 1'b1; rw = 1'b0; mar = 16'h0ABC; mdr_in = 16'h7777;
    @(posedge Clk); #1 start = 1'b0;
    @(negedge Clk); @(negedge Clk);
    chk("rstmid_we_low", we_n, 1'b0);
    #2 Reset = 1'b0;
    #1;
    chk("rstmid_async", {ce_n, oe_n, we_n, mem_wdata_oe, busy, ready, err}, 7'b1110000);
    chk("rstmid_data", {mdr_out, mem_addr, mem_wdata}, 48'h0);
    @(negedge Clk);
    Reset = 1'b1;
    run(1'b1, 16'h2222, 16'h0000, 16'hC0DE, lat, wlow, s1, s2);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_mdr", mdr_out, 16'hC0DE);
    @(negedge Clk);

    lat_x(1, lat);
    chk("w1_lat", lat, 3);
    @(negedge Clk);
    lat_x(15, lat);
    chk("w15_lat", lat, 17);

    chk("no_oe_we_overlap", ovl, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
